// File: rtl/alu_bist_controller_if.sv
// BIST controller bundle: ALU stimulus/response plus run control and status.
// master is the controller side, slave is the environment/ALU side.
interface alu_bist_controller_if #(
   parameter int WIDTH = 4,
   parameter int ERRW  = 8
);
   logic                 start;
   logic                 abort;
   logic [WIDTH-1:0]     alu_a;
   logic [WIDTH-1:0]     alu_b;
   logic [1:0]           alu_op;
   logic [WIDTH-1:0]     alu_result;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [ERRW-1:0]      err_count;
   logic [2*WIDTH+1:0]   first_fail_vec;
   logic [WIDTH-1:0]     first_fail_result;

   modport master (
      input  start, abort, alu_result,
      output alu_a, alu_b, alu_op,
      output busy, done, pass, err_count,
      output first_fail_vec, first_fail_result
   );

   modport slave (
      output start, abort, alu_result,
      input  alu_a, alu_b, alu_op,
      input  busy, done, pass, err_count,
      input  first_fail_vec, first_fail_result
   );
endinterface

// File: rtl/alu_bist_controller.sv
// Exhaustive ALU self-test: sweeps every {op,A,B}, checks against a golden
// model, counts mismatches (saturating) and captures the first failure.
module alu_bist_controller #(
   parameter int WIDTH = 4,
   parameter int ERRW  = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   alu_bist_controller_if.master bus
);
   localparam int VW = 2*WIDTH + 2;
   localparam logic [VW-1:0] LAST = '1;
   localparam logic [ERRW-1:0] ESAT = '1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e          state_q, state_d;
   logic [VW-1:0]   vec_q, vec_d;
   logic [ERRW-1:0] err_q, err_d;
   logic [VW-1:0]   ffv_q, ffv_d;
   logic [WIDTH-1:0] ffr_q, ffr_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;

   logic [1:0]       op;
   logic [WIDTH-1:0] a, b, gold;
   logic             miss;

   // The driven vector register doubles as the sweep index.
   assign op = vec_q[VW-1 -: 2];
   assign a  = vec_q[2*WIDTH-1 -: WIDTH];
   assign b  = vec_q[WIDTH-1:0];

   always_comb begin
      gold = '0;
      unique case (op)
         2'b00: gold = a + b;
         2'b01: gold = a - b;
         2'b10: gold = a & b;
         2'b11: gold = a | b;
      endcase
   end

   assign miss = (bus.alu_result != gold);

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      err_d   = err_q;
      ffv_d   = ffv_q;
      ffr_d   = ffr_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = RUN;
               vec_d   = '0;
               err_d   = '0;
               ffv_d   = '0;
               ffr_d   = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d = IDLE;
               vec_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b0;
            end else begin
               // err_q==0 marks the first mismatch: the counter never wraps.
               if (miss) begin
                  if (err_q == '0) begin
                     ffv_d = vec_q;
                     ffr_d = bus.alu_result;
                  end
                  if (err_q != ESAT) err_d = err_q + 1'b1;
               end
               if (vec_q == LAST) begin
                  state_d = DONE;
                  vec_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == '0);
               end else begin
                  vec_d = vec_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         err_q   <= '0;
         ffv_q   <= '0;
         ffr_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         ffr_q   <= ffr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign bus.alu_op            = op;
   assign bus.alu_a             = a;
   assign bus.alu_b             = b;
   assign bus.busy              = busy_q;
   assign bus.done              = done_q;
   assign bus.pass              = pass_q;
   assign bus.err_count         = err_q;
   assign bus.first_fail_vec    = ffv_q;
   assign bus.first_fail_result = ffr_q;
endmodule

// File: tb/tb_alu_bist_controller.sv
// Bench for alu_bist_controller: table runs, random fault maps checked
// against a per-vector reference, plus abort/restart/reset sequences.
module tb_alu_bist_controller;
   localparam int N = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_bist_controller_if #(.WIDTH(4), .ERRW(8)) bus ();

   alu_bist_controller #(.WIDTH(4), .ERRW(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [3:0] mask [N];

   function automatic logic [3:0] gold(int v);
      int op, a, b;
      op = v / 256;
      a = (v / 16) % 16;
      b = v % 16;
      case (op)
         0: return 4'((a + b) % 16);
         1: return 4'((a - b + 16) % 16);
         2: return 4'(a & b);
         default: return 4'(a | b);
      endcase
   endfunction

   // Faulty ALU: golden result XOR a per-vector fault mask.
   always_comb begin
      int v;
      v = int'({bus.alu_op, bus.alu_a, bus.alu_b});
      bus.alu_result = gold(v) ^ mask[v];
   end

   function automatic int curvec();
      return int'({bus.alu_op, bus.alu_a, bus.alu_b});
   endfunction

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // kind 0 good, 1 ADD F+F bit0 flip, 2 bit0 stuck 0, 3 random
   task automatic set_mask(int kind, int pct);
      for (int v = 0; v < N; v++) begin
         mask[v] = 4'h0;
         case (kind)
            1: if (v == 'h0FF) mask[v] = 4'h1;
            2: mask[v] = {3'b000, gold(v)[0]};
            3: if ($urandom_range(99) < pct)
                  mask[v] = 4'($urandom_range(15, 1));
            default: ;
         endcase
      end
   endtask

   task automatic ref_run(output int e, output int fv,
                          output int fr, output int p);
      logic [3:0] r;
      e = 0; fv = 0; fr = 0;
      for (int v = 0; v < N; v++) begin
         r = gold(v) ^ mask[v];
         if (r != gold(v)) begin
            if (e == 0) begin
               fv = v;
               fr = int'(r);
            end
            if (e < 255) e++;
         end
      end
      p = (e == 0) ? 1 : 0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
   endtask

   // Start a run and step to done; returns cycles from start edge to done.
   task automatic run(input bit extra, output int cyc);
      bit seq_ok;
      pulse_start();
      chk("start_busy", int'(bus.busy), 1);
      chk("start_vec0", curvec(), 0);
      chk("start_clr", int'(bus.err_count), 0);
      cyc = 0;
      seq_ok = 1;
      while (cyc < 2000) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         cyc++;
         if (bus.done) break;
         if (curvec() != cyc || !bus.busy) seq_ok = 0;
         if (extra && cyc == 50) bus.start = 1'b1;
      end
      chk("vec_seq", int'(seq_ok), 1);
      chk("run_len", cyc, N);
      chk("end_busy", int'(bus.busy), 0);
      chk("end_alu", curvec(), 0);
   endtask

   typedef struct {
      int kind;
      int e_err;
      int e_fv;
      int e_fr;
      int e_pass;
   } vec_t;

   vec_t tbl [3];

   initial begin
      int cyc, e, fv, fr, p;
      tbl[0] = '{0, 0,    0,     0, 1};
      tbl[1] = '{1, 1,    'h0FF, 'hF, 0};
      tbl[2] = '{2, 'hFF, 'h001, 0, 0};

      bus.start = 1'b0;
      bus.abort = 1'b0;
      set_mask(0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_pass", int'(bus.pass), 0);
      chk("rst_err", int'(bus.err_count), 0);
      chk("rst_alu", curvec(), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 3; i++) begin
         set_mask(tbl[i].kind, 0);
         run(1'b0, cyc);
         chk($sformatf("t%0d_done", i), int'(bus.done), 1);
         chk($sformatf("t%0d_err", i), int'(bus.err_count), tbl[i].e_err);
         chk($sformatf("t%0d_ffv", i), int'(bus.first_fail_vec), tbl[i].e_fv);
         chk($sformatf("t%0d_ffr", i), int'(bus.first_fail_result), tbl[i].e_fr);
         chk($sformatf("t%0d_pass", i), int'(bus.pass), tbl[i].e_pass);
      end

      for (int i = 0; i < 5; i++) begin
         set_mask(3, (i == 4) ? 40 : i);
         ref_run(e, fv, fr, p);
         run(1'b0, cyc);
         chk($sformatf("r%0d_err", i), int'(bus.err_count), e);
         chk($sformatf("r%0d_ffv", i), int'(bus.first_fail_vec), fv);
         chk($sformatf("r%0d_ffr", i), int'(bus.first_fail_result), fr);
         chk($sformatf("r%0d_pass", i), int'(bus.pass), p);
      end

      // abort while DONE is ignored
      @(posedge clk); #1 bus.abort = 1'b1;
      @(posedge clk); #1 bus.abort = 1'b0;
      chk("abort_done_keep", int'(bus.done), 1);

      // abort mid-run keeps partial error status
      set_mask(2, 0);
      pulse_start();
      repeat (100) @(posedge clk);
      #1 bus.abort = 1'b1;
      @(posedge clk); #1 bus.abort = 1'b0;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_alu", curvec(), 0);
      chk("abort_errkept", int'(bus.err_count != 0), 1);
      chk("abort_ffv", int'(bus.first_fail_vec), 'h001);
      repeat (5) @(posedge clk);
      #1 chk("abort_idle", curvec(), 0);

      set_mask(0, 0);
      run(1'b0, cyc);
      chk("rerun_pass", int'(bus.pass), 1);
      chk("rerun_err", int'(bus.err_count), 0);

      // second start mid-run must not restart the sweep
      run(1'b1, cyc);
      chk("midstart_pass", int'(bus.pass), 1);

      // async reset mid-run
      set_mask(2, 0);
      pulse_start();
      repeat (30) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_err", int'(bus.err_count), 0);
      chk("arst_ffv", int'(bus.first_fail_vec), 0);
      chk("arst_alu", curvec(), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("post_busy", int'(bus.busy), 0);
      chk("post_done", int'(bus.done), 0);
      chk("post_alu", curvec(), 0);
      chk("post_err", int'(bus.err_count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
